// File: rtl/qos_pkt_tx_if.sv
// qos_pkt_tx_if
// Packet ingress handshake for qos_pkt_tx.
//   pkt_data  [3:0] : packet, MSB first; [3:2] priority class, [1:0] payload
//   pkt_valid       : pkt_data is valid
//   pkt_ready       : transmitter can accept; transfer when valid && ready at a rising edge
// Modports: master drives data/valid, slave (the transmitter) drives ready.
interface qos_pkt_tx_if;
    logic [3:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;

    modport master (output pkt_data, output pkt_valid, input pkt_ready);
    modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/qos_pkt_tx.sv
// qos_pkt_tx
// Serialises 4-bit packets onto the active-low start/one/zero push-button
// lines sampled by the QoS ingress deserialiser. One frame per packet:
// START pulse, then bits 3..0 each as a one_n or zero_n pulse, separated
// by all-high gaps, followed by an all-high tail.
// Ports:
//   clk         : system clock, all state on rising edge
//   rst         : asynchronous active-low reset
//   pkt         : packet handshake (qos_pkt_tx_if.slave)
//   start_n     : frame-start pulse, active-low, registered
//   one_n       : '1' bit pulse, active-low, registered
//   zero_n      : '0' bit pulse, active-low, registered
//   busy        : frame in progress (START through TAIL)
//   sent_count  : frames completed, wraps 255->0
// Parameters: PULSE_CYCLES / GAP_CYCLES (1..65535) set pulse and gap widths.
// Build option: define QOS_TX_FIFO_EN for a 4-entry FIFO queue; otherwise
// the queue is a single holding register.
module qos_pkt_tx #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    qos_pkt_tx_if.slave      pkt,
    output logic             start_n,
    output logic             one_n,
    output logic             zero_n,
    output logic             busy,
    output logic [7:0]       sent_count
);

    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, GAP, BIT, TAIL} state_t;

    state_t      state_reg;
    logic [15:0] phase_reg;
    logic [1:0]  idx_reg;
    logic [3:0]  shift_reg;

    logic        q_empty;
    logic        q_full;
    logic [3:0]  q_head;
    logic        push;
    logic        pop;

    // Push is gated by the current full flag even if a pop happens in the
    // same cycle, so ready never depends on the FSM.
    assign pkt.pkt_ready = !q_full;
    assign push          = pkt.pkt_valid && !q_full;

    // A frame launches from IDLE, or directly from the last TAIL cycle so
    // back-to-back frames are contiguous.
    always_comb begin
        pop = 1'b0;
        if (!q_empty) begin
            if (state_reg == IDLE)
                pop = 1'b1;
            else if (state_reg == TAIL && phase_reg == GAP_LAST)
                pop = 1'b1;
        end
    end

`ifdef QOS_TX_FIFO_EN
    logic [3:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= pkt.pkt_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign q_empty = (count_reg == 3'd0);
    assign q_full  = count_reg[2];
    assign q_head  = fifo_mem[rd_ptr_reg];
`else
    logic [3:0] hold_reg;
    logic       hold_valid_reg;

    // Push only while empty and pop only while full, so they never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg       <= 4'd0;
            hold_valid_reg <= 1'b0;
        end else if (push) begin
            hold_reg       <= pkt.pkt_data;
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign q_empty = !hold_valid_reg;
    assign q_full  = hold_valid_reg;
    assign q_head  = hold_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            phase_reg  <= 16'd0;
            idx_reg    <= 2'd0;
            shift_reg  <= 4'd0;
            start_n    <= 1'b1;
            one_n      <= 1'b1;
            zero_n     <= 1'b1;
            busy       <= 1'b0;
            sent_count <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= q_head;
                        idx_reg   <= 2'd3;
                        start_n   <= 1'b0;
                        busy      <= 1'b1;
                        phase_reg <= 16'd0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (phase_reg == PULSE_LAST) begin
                        start_n   <= 1'b1;
                        phase_reg <= 16'd0;
                        state_reg <= GAP;
                    end else begin
                        phase_reg <= phase_reg + 16'd1;
                    end
                end
                GAP: begin
                    if (phase_reg == GAP_LAST) begin
                        phase_reg <= 16'd0;
                        state_reg <= BIT;
                        if (shift_reg[idx_reg])
                            one_n <= 1'b0;
                        else
                            zero_n <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + 16'd1;
                    end
                end
                BIT: begin
                    if (phase_reg == PULSE_LAST) begin
                        one_n     <= 1'b1;
                        zero_n    <= 1'b1;
                        phase_reg <= 16'd0;
                        if (idx_reg != 2'd0) begin
                            idx_reg   <= idx_reg - 2'd1;
                            state_reg <= GAP;
                        end else begin
                            state_reg <= TAIL;
                        end
                    end else begin
                        phase_reg <= phase_reg + 16'd1;
                    end
                end
                TAIL: begin
                    if (phase_reg == GAP_LAST) begin
                        sent_count <= sent_count + 8'd1;
                        phase_reg  <= 16'd0;
                        if (pop) begin
                            shift_reg <= q_head;
                            idx_reg   <= 2'd3;
                            start_n   <= 1'b0;
                            state_reg <= START;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        phase_reg <= phase_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qos_pkt_tx.sv
// tb_qos_pkt_tx
// Directed bench for qos_pkt_tx. Two instances: dut4 (PULSE=GAP=4) and
// dut1 (PULSE=GAP=1). Inputs are driven and outputs sampled on the falling
// edge. Expected line patterns come from a frame-timing model fed with the
// packets the bench itself pushed.
module tb_qos_pkt_tx;

`ifdef QOS_TX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk = ~clk;

    qos_pkt_tx_if if4 ();
    qos_pkt_tx_if if1 ();

    logic       start4, one4, zero4, busy4;
    logic [7:0] cnt4;
    logic       start1, one1, zero1, busy1;
    logic [7:0] cnt1;

    qos_pkt_tx #(.PULSE_CYCLES(4), .GAP_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .pkt(if4),
        .start_n(start4), .one_n(one4), .zero_n(zero4),
        .busy(busy4), .sent_count(cnt4)
    );

    qos_pkt_tx #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .pkt(if1),
        .start_n(start1), .one_n(one1), .zero_n(zero1),
        .busy(busy1), .sent_count(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] stim_d  [8];
    logic       stim_r  [8];
    logic [3:0] frame_d [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {start_n, one_n, zero_n, busy}
    function automatic logic [3:0] obs(input int sel);
        return (sel == 4) ? {start4, one4, zero4, busy4} : {start1, one1, zero1, busy1};
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 4) ? if4.pkt_ready : if1.pkt_ready;
    endfunction

    function automatic logic [7:0] cnt(input int sel);
        return (sel == 4) ? cnt4 : cnt1;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [3:0] d);
        if (sel == 4) begin
            if4.pkt_valid = v;
            if4.pkt_data  = d;
        end else begin
            if1.pkt_valid = v;
            if1.pkt_data  = d;
        end
    endtask

    task automatic do_reset(input int sel);
        drive(sel, 1'b0, 4'd0);
        if (sel == 4) rst4 = 1'b0; else rst1 = 1'b0;
        repeat (3) @(negedge clk);
        if (sel == 4) rst4 = 1'b1; else rst1 = 1'b1;
    endtask

    // Expected {start_n, one_n, zero_n, busy} at cycle c (cycle 0 = first
    // start_n-low cycle) for nf contiguous frames carrying frame_d[].
    function automatic logic [3:0] exp_obs(input int c, input int p, input int g, input int nf);
        int slot;
        int f;
        int r;
        int s;
        int off;
        logic [3:0] d;
        logic [2:0] ln;
        slot = p + g;
        f    = c / (5 * slot);
        r    = c % (5 * slot);
        s    = r / slot;
        off  = r % slot;
        ln   = 3'b111;
        if (f < nf) begin
            d = frame_d[f];
            if (off < p) begin
                if (s == 0)
                    ln = 3'b011;
                else if (d[4 - s])
                    ln = 3'b101;
                else
                    ln = 3'b110;
            end
        end
        return {ln, (f < nf)};
    endfunction

    // Present stim_d[i] at cycle i-2 (checking ready against stim_r[i]),
    // then compare the lines with the model for cycles 0..n_cyc-1 and
    // finally the completed-frame count.
    task automatic run(input int sel, input int n_stim, input int nf, input int n_cyc, input int exp_cnt);
        int pg;
        pg = (sel == 4) ? 4 : 1;
        for (int c = -2; c < n_cyc; c++) begin
            @(negedge clk);
            if (c + 2 < n_stim) begin
                drive(sel, 1'b1, stim_d[c + 2]);
                $display("txn dut%0d cycle=%0d data=%b ready=%b", sel, c, stim_d[c + 2], rdy(sel));
                check("pkt_ready", 32'(rdy(sel)), 32'(stim_r[c + 2]));
            end else begin
                drive(sel, 1'b0, 4'd0);
            end
            if (c >= 0)
                check($sformatf("lines_c%0d", c), 32'(obs(sel)), 32'(exp_obs(c, pg, pg, nf)));
        end
        check("sent_count", 32'(cnt(sel)), 32'(exp_cnt));
    endtask

    initial begin
        logic [3:0] pk [6];
        int n_stim;
        int nf;
        int tmo;
        int bad;

        drive(4, 1'b0, 4'd0);
        drive(1, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_lines4", 32'(obs(4)), 32'h0000000e);
        check("rst_ready4", 32'(rdy(4)), 32'd1);
        check("rst_count4", 32'(cnt(4)), 32'd0);
        check("rst_lines1", 32'(obs(1)), 32'h0000000e);

        // Single frame 1101, PULSE=GAP=4.
        stim_d[0] = 4'b1101; stim_r[0] = 1'b1; frame_d[0] = 4'b1101;
        run(4, 1, 1, 44, 1);

        // Single frame 0000, PULSE=GAP=1: 10-cycle frame.
        stim_d[0] = 4'b0000; stim_r[0] = 1'b1; frame_d[0] = 4'b0000;
        run(1, 1, 1, 12, 1);

        // Back-to-back pushes with pkt_valid held.
        do_reset(4);
        pk = '{4'b1001, 4'b0110, 4'b1111, 4'b0001, 4'b1100, 4'b0011};
        for (int i = 0; i < 6; i++) begin
            stim_d[i]  = FIFO_MODE ? pk[i] : ((i == 0) ? pk[0] : pk[1]);
            stim_r[i]  = FIFO_MODE ? (i < 5) : (i != 1);
            frame_d[i] = pk[i];
        end
        n_stim = FIFO_MODE ? 6 : 3;
        nf     = FIFO_MODE ? 5 : 2;
        run(4, n_stim, nf, nf * 40 + 4, nf);

        // Reset during bit1 with further packets queued.
        do_reset(4);
        stim_d[0] = 4'b1011; stim_d[1] = 4'b0110; stim_d[2] = 4'b0110;
        stim_r[0] = 1'b1;    stim_r[1] = FIFO_MODE; stim_r[2] = 1'b1;
        frame_d[0] = 4'b1011; frame_d[1] = 4'b0110;
        run(4, 3, 2, 26, 0);
        #2 rst4 = 1'b0;
        #1;
        check("async_rst_lines", 32'(obs(4)), 32'h0000000e);
        check("async_rst_ready", 32'(rdy(4)), 32'd1);
        check("async_rst_count", 32'(cnt(4)), 32'd0);
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (obs(4) !== 4'b1110) bad++;
        end
        check("post_rst_idle", 32'(bad), 32'd0);
        check("post_rst_count", 32'(cnt(4)), 32'd0);

        // sent_count wrap over 256 frames.
        do_reset(1);
        tmo = 0;
        for (int n = 1; n <= 256; n++) begin
            for (int w = 0; w < 20 && !rdy(1); w++) @(negedge clk);
            drive(1, 1'b1, 4'(n));
            @(negedge clk);
            drive(1, 1'b0, 4'd0);
            for (int w = 0; w < 30 && cnt(1) != 8'(n); w++) @(negedge clk);
            if (cnt(1) != 8'(n)) tmo++;
            $display("txn dut1 wrap frame=%0d sent_count=%0d", n, cnt(1));
            if (n == 255) check("wrap_255", 32'(cnt(1)), 32'd255);
            if (n == 256) check("wrap_256", 32'(cnt(1)), 32'd0);
        end
        check("wrap_timeouts", 32'(tmo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
